vrc_irq_timer: RTL and testbench

Parametrised multi-channel VRC-style IRQ timer: the next-generation replacement for the single 8-bit VRC IRQ counter used by the VRC-family mapper chips. It provides CHANNELS independent counters of CNT_W bits. Each counter runs in either CPU-cycle mode or scanline-prescaled mode, with programmable prescaler constants. The block sits beside the mapper register decode: the mapper supplies per-register chip enables and a channel select, and the block drives the cartridge IRQ line.

---
 rtl/vrc_irq_pkg.sv | 20 ++
 rtl/vrc_irq_timer_if.sv | 32 +++
 rtl/vrc_irq_chan.sv | 114 +++++++++++
 rtl/vrc_irq_timer.sv | 55 +++++
 tb/tb_vrc_irq_timer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/vrc_irq_pkg.sv
// Shared constants and sizing helpers for the multi-channel VRC IRQ timer.
package vrc_irq_pkg;

    localparam int CTRL_EN_ACK = 0;
    localparam int CTRL_EN     = 1;
    localparam int CTRL_MODE   = 2;

    localparam int PRE_PERIOD_DEF = 341;
    localparam int PRE_STEP_DEF   = 3;

    // Signed prescaler must hold PRE_PERIOD+PRE_STEP plus a sign bit.
    function automatic int pre_width(input int period, input int step);
        return $clog2(period + step + 1) + 1;
    endfunction

    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/vrc_irq_timer_if.sv
// Mapper-side bus of the IRQ timer: register strobes in, IRQ and counter readback out.
interface vrc_irq_timer_if
    import vrc_irq_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 8
) ();

    localparam int SEL_W = sel_width(CHANNELS);

    logic [7:0]          cpu_data;
    logic                cpu_rw;
    logic [SEL_W-1:0]    ch_sel;
    logic                ce_lat_lo;
    logic                ce_lat_hi;
    logic                ce_ctrl;
    logic                ce_ackn;
    logic [CHANNELS-1:0] irq_pend;
    logic                irq_n;
    logic [CNT_W-1:0]    cnt_dout;

    modport master (
        output cpu_data, cpu_rw, ch_sel, ce_lat_lo, ce_lat_hi, ce_ctrl, ce_ackn,
        input  irq_pend, irq_n, cnt_dout
    );

    modport slave (
        input  cpu_data, cpu_rw, ch_sel, ce_lat_lo, ce_lat_hi, ce_ctrl, ce_ackn,
        output irq_pend, irq_n, cnt_dout
    );

endinterface

// File: rtl/vrc_irq_chan.sv
// One timer channel: latch, up-counter with overflow reload, and scanline prescaler.
module vrc_irq_chan
    import vrc_irq_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int PRE_PERIOD = PRE_PERIOD_DEF,
    parameter int PRE_STEP   = PRE_STEP_DEF
) (
    input  logic             cpu_m2,
    input  logic             rst_n,
    input  logic             wr_lat_lo,
    input  logic             wr_lat_hi,
    input  logic             wr_ctrl,
    input  logic             wr_ackn,
    input  logic [7:0]       data,
    output logic [CNT_W-1:0] cnt,
    output logic             pend
);

    localparam int PRE_W = pre_width(PRE_PERIOD, PRE_STEP);
    localparam logic signed [PRE_W-1:0] PRE_RELOAD = PRE_W'(PRE_PERIOD);
    localparam logic signed [PRE_W-1:0] PRE_DEC    = PRE_W'(PRE_STEP);
    localparam logic signed [PRE_W-1:0] PRE_ZERO   = '0;
    localparam logic [CNT_W-1:0] LO_MASK = CNT_W'(16'h00FF);
    localparam logic [CNT_W-1:0] HI_MASK = CNT_W'(16'hFF00);

    logic [CNT_W-1:0]        latch_q, latch_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [PRE_W-1:0] pre_q, pre_d;
    logic                    en_ack_q, en_ack_d;
    logic                    en_q, en_d;
    logic                    mode_q, mode_d;
    logic                    pend_q, pend_d;
    logic signed [PRE_W-1:0] pre_sub;
    logic                    tick;

    always_ff @(negedge cpu_m2 or negedge rst_n) begin
        if (!rst_n) begin
            latch_q  <= '0;
            cnt_q    <= '0;
            pre_q    <= PRE_RELOAD;
            en_ack_q <= 1'b0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            en_ack_q <= en_ack_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a hold default first so no path can infer a latch.
        latch_d  = latch_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        en_ack_d = en_ack_q;
        en_d     = en_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        tick     = 1'b0;
        pre_sub  = pre_q - PRE_DEC;

        if (en_q) begin
            if (mode_q) begin
                tick = 1'b1;
            end else if (pre_sub <= PRE_ZERO) begin
                pre_d = pre_sub + PRE_RELOAD;
                tick  = 1'b1;
            end else begin
                pre_d = pre_sub;
            end
        end

        // Ack is applied before the tick so a coinciding overflow re-sets pend.
        if (wr_ackn) begin
            pend_d = 1'b0;
            en_d   = en_ack_q;
        end

        // Overflow reload reads latch_q, so a same-edge latch write only affects later reloads.
        if (tick) begin
            if (&cnt_q) begin
                cnt_d  = latch_q;
                pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // With CNT_W=8 the high mask is empty, so high-byte writes drop out.
        if (wr_lat_lo) latch_d = (latch_q & ~LO_MASK) | CNT_W'(data);
        if (wr_lat_hi) latch_d = (latch_q & ~HI_MASK) | CNT_W'({data, 8'h00});

        if (wr_ctrl) begin
            mode_d   = data[CTRL_MODE];
            en_d     = data[CTRL_EN];
            en_ack_d = data[CTRL_EN_ACK];
            pend_d   = 1'b0;
            cnt_d    = data[CTRL_EN] ? latch_q : cnt_q;
            pre_d    = data[CTRL_EN] ? PRE_RELOAD : pre_q;
        end
    end

    assign cnt  = cnt_q;
    assign pend = pend_q;

endmodule

// File: rtl/vrc_irq_timer.sv
// Multi-channel VRC IRQ timer: per-channel write decode, IRQ OR-reduction, counter readback mux.
module vrc_irq_timer
    import vrc_irq_pkg::*;
#(
    parameter int CHANNELS   = 1,
    parameter int CNT_W      = 8,
    parameter int PRE_PERIOD = PRE_PERIOD_DEF,
    parameter int PRE_STEP   = PRE_STEP_DEF
) (
    input logic                cpu_m2,
    input logic                rst_n,
    vrc_irq_timer_if.slave     bus
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic                wr_cycle;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] pend;

    assign wr_cycle = !bus.cpu_rw;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic hit;
        assign hit = wr_cycle && (bus.ch_sel == SEL_W'(i));

        vrc_irq_chan #(
            .CNT_W      (CNT_W),
            .PRE_PERIOD (PRE_PERIOD),
            .PRE_STEP   (PRE_STEP)
        ) u_chan (
            .cpu_m2    (cpu_m2),
            .rst_n     (rst_n),
            .wr_lat_lo (hit && bus.ce_lat_lo),
            .wr_lat_hi (hit && bus.ce_lat_hi),
            .wr_ctrl   (hit && bus.ce_ctrl),
            .wr_ackn   (hit && bus.ce_ackn),
            .data      (bus.cpu_data),
            .cnt       (cnt[i]),
            .pend      (pend[i])
        );
    end

    assign bus.irq_pend = pend;
    assign bus.irq_n    = !(|pend);

    // Out-of-range selects read back as zero.
    always_comb begin
        bus.cnt_dout = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.ch_sel == SEL_W'(i)) bus.cnt_dout = cnt[i];
        end
    end

endmodule

// File: tb/tb_vrc_irq_timer.sv
// Directed bench: 8-bit single channel, 16-bit single channel and 4-channel timers on one M2 clock.
module tb_vrc_irq_timer;

    typedef enum {K_LO, K_HI, K_CTRL, K_ACKN} wkind_t;

    logic       cpu_m2 = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_rw = 1'b1;
    logic [1:0] sel = 2'd0;
    logic       ce_lo = 1'b0, ce_hi = 1'b0, ce_ctrl = 1'b0, ce_ackn = 1'b0;
    int         tgt = 0;
    int         total = 0;
    int         bad = 0;
    int         n;

    always #5 cpu_m2 = ~cpu_m2;

    vrc_irq_timer_if #(.CHANNELS(1), .CNT_W(8))  if8  ();
    vrc_irq_timer_if #(.CHANNELS(1), .CNT_W(16)) if16 ();
    vrc_irq_timer_if #(.CHANNELS(4), .CNT_W(8))  if4  ();

    assign if8.cpu_data  = cpu_data;
    assign if8.cpu_rw    = cpu_rw;
    assign if8.ch_sel    = sel[0];
    assign if8.ce_lat_lo = ce_lo   && (tgt == 0);
    assign if8.ce_lat_hi = ce_hi   && (tgt == 0);
    assign if8.ce_ctrl   = ce_ctrl && (tgt == 0);
    assign if8.ce_ackn   = ce_ackn && (tgt == 0);

    assign if16.cpu_data  = cpu_data;
    assign if16.cpu_rw    = cpu_rw;
    assign if16.ch_sel    = sel[0];
    assign if16.ce_lat_lo = ce_lo   && (tgt == 1);
    assign if16.ce_lat_hi = ce_hi   && (tgt == 1);
    assign if16.ce_ctrl   = ce_ctrl && (tgt == 1);
    assign if16.ce_ackn   = ce_ackn && (tgt == 1);

    assign if4.cpu_data  = cpu_data;
    assign if4.cpu_rw    = cpu_rw;
    assign if4.ch_sel    = sel;
    assign if4.ce_lat_lo = ce_lo   && (tgt == 2);
    assign if4.ce_lat_hi = ce_hi   && (tgt == 2);
    assign if4.ce_ctrl   = ce_ctrl && (tgt == 2);
    assign if4.ce_ackn   = ce_ackn && (tgt == 2);

    vrc_irq_timer #(.CHANNELS(1), .CNT_W(8))  dut8  (.cpu_m2(cpu_m2), .rst_n(rst_n), .bus(if8));
    vrc_irq_timer #(.CHANNELS(1), .CNT_W(16)) dut16 (.cpu_m2(cpu_m2), .rst_n(rst_n), .bus(if16));
    vrc_irq_timer #(.CHANNELS(4), .CNT_W(8))  dut4  (.cpu_m2(cpu_m2), .rst_n(rst_n), .bus(if4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns one falling edge later, sampling half a period after it.
    task automatic step();
        @(posedge cpu_m2);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wr(input int t, input logic [1:0] s, input wkind_t k, input logic [7:0] d);
        tgt      = t;
        sel      = s;
        cpu_data = d;
        cpu_rw   = 1'b0;
        ce_lo    = (k == K_LO);
        ce_hi    = (k == K_HI);
        ce_ctrl  = (k == K_CTRL);
        ce_ackn  = (k == K_ACKN);
        step();
        ce_lo    = 1'b0;
        ce_hi    = 1'b0;
        ce_ctrl  = 1'b0;
        ce_ackn  = 1'b0;
        cpu_rw   = 1'b1;
    endtask

    // Edges until the 8-bit timer pends; 400 means the bound expired.
    task automatic wait_pend8(output int cnt_edges);
        cnt_edges = 0;
        do begin
            step();
            cnt_edges++;
        end while (if8.irq_pend[0] !== 1'b1 && cnt_edges < 400);
    endtask

    initial begin
        #1;
        check("rst_irq_n8", if8.irq_n, 1);
        check("rst_pend8", if8.irq_pend, 0);
        check("rst_cnt8", if8.cnt_dout, 0);
        check("rst_cnt16", if16.cnt_dout, 0);
        check("rst_pend4", if4.irq_pend, 0);
        #11 rst_n = 1'b1;
        step();

        // Cycle mode, 8-bit
        wr(0, 0, K_LO, 8'hFD);
        wr(0, 0, K_CTRL, 8'h07);
        check("cyc_load", if8.cnt_dout, 'hFD);
        check("cyc_load_pend", if8.irq_pend, 0);
        step(); check("cyc_e1", if8.cnt_dout, 'hFE);
        step(); check("cyc_e2", if8.cnt_dout, 'hFF);
        check("cyc_e2_pend", if8.irq_pend, 0);
        step(); check("cyc_ovf_cnt", if8.cnt_dout, 'hFD);
        check("cyc_ovf_pend", if8.irq_pend, 1);
        check("cyc_ovf_irq_n", if8.irq_n, 0);
        wr(0, 0, K_ACKN, 8'h00);
        check("ack_pend", if8.irq_pend, 0);
        check("ack_irq_n", if8.irq_n, 1);
        check("ack_cnt", if8.cnt_dout, 'hFE);
        step(); check("ack_e2_pend", if8.irq_pend, 0);
        step(); check("ack_ovf_pend", if8.irq_pend, 1);
        check("ack_ovf_cnt", if8.cnt_dout, 'hFD);

        // Collisions on an overflow edge
        steps(2);
        wr(0, 0, K_ACKN, 8'h00);
        check("col_ack_pend", if8.irq_pend, 1);
        check("col_ack_cnt", if8.cnt_dout, 'hFD);
        steps(2);
        wr(0, 0, K_CTRL, 8'h07);
        check("col_ctrl_pend", if8.irq_pend, 0);
        check("col_ctrl_cnt", if8.cnt_dout, 'hFD);
        steps(2);
        wr(0, 0, K_LO, 8'h10);
        check("col_lat_cnt", if8.cnt_dout, 'hFD);
        check("col_lat_pend", if8.irq_pend, 1);
        steps(3);
        check("col_lat_next", if8.cnt_dout, 'h10);

        // Asynchronous reset with an IRQ pending
        check("pre_rst_irq_n", if8.irq_n, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_irq_n", if8.irq_n, 1);
        check("async_rst_pend", if8.irq_pend, 0);
        check("async_rst_cnt", if8.cnt_dout, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_cnt", if8.cnt_dout, 0);

        // Writes with ch_sel beyond CHANNELS are dropped
        wr(0, 1, K_LO, 8'hAA);
        wr(0, 0, K_CTRL, 8'h06);
        check("sel_oob_ignored", if8.cnt_dout, 0);

        // Scanline mode 114/114/113
        wr(0, 0, K_LO, 8'hFF);
        wr(0, 0, K_CTRL, 8'h03);
        check("scan_load", if8.cnt_dout, 'hFF);
        wait_pend8(n);
        check("scan_first", n, 114);
        wr(0, 0, K_ACKN, 8'h00);
        wait_pend8(n);
        check("scan_second", n + 1, 114);
        wr(0, 0, K_ACKN, 8'h00);
        wait_pend8(n);
        check("scan_third", n + 1, 113);
        wr(0, 0, K_CTRL, 8'h02);
        check("scan_ctrl_clr", if8.irq_pend, 0);
        wait_pend8(n);
        check("scan_restart", n, 114);
        wr(0, 0, K_ACKN, 8'h00);
        check("scan_stop_ack", if8.irq_pend, 0);
        steps(120);
        check("scan_stopped", if8.irq_pend, 0);
        check("scan_stopped_irq_n", if8.irq_n, 1);

        // 16-bit counter
        wr(1, 0, K_LO, 8'hFE);
        wr(1, 0, K_HI, 8'hFF);
        wr(1, 0, K_CTRL, 8'h06);
        check("w16_load", if16.cnt_dout, 'hFFFE);
        step(); check("w16_e1", if16.cnt_dout, 'hFFFF);
        check("w16_e1_pend", if16.irq_pend, 0);
        step(); check("w16_ovf", if16.cnt_dout, 'hFFFE);
        check("w16_ovf_pend", if16.irq_pend, 1);
        step(); check("w16_e3", if16.cnt_dout, 'hFFFF);
        step(); check("w16_e4", if16.cnt_dout, 'hFFFE);

        // Four channels: ch0 cycle, ch3 scanline, ch2 touched
        wr(2, 0, K_LO, 8'hF0);
        wr(2, 0, K_CTRL, 8'h07);
        wr(2, 3, K_LO, 8'hFF);
        wr(2, 3, K_CTRL, 8'h02);
        wr(2, 2, K_LO, 8'h55);
        wr(2, 2, K_CTRL, 8'h00);
        check("ch2_cnt", if4.cnt_dout, 0);
        check("ch2_pend", if4.irq_pend, 0);
        sel = 2'd0;
        #1;
        check("ch0_cnt", if4.cnt_dout, 'hF4);
        steps(11);
        check("ch0_pre_ovf", if4.cnt_dout, 'hFF);
        check("ch0_pre_ovf_pend", if4.irq_pend, 4'b0000);
        step();
        check("ch0_ovf_pend", if4.irq_pend, 4'b0001);
        check("ch0_ovf_cnt", if4.cnt_dout, 'hF0);
        check("ch0_ovf_irq_n", if4.irq_n, 0);
        sel = 2'd3;
        #1;
        check("ch3_cnt", if4.cnt_dout, 'hFF);
        steps(99);
        check("ch3_pre_ovf", if4.irq_pend, 4'b0001);
        step();
        check("ch3_ovf", if4.irq_pend, 4'b1001);
        wr(2, 0, K_ACKN, 8'h00);
        check("ch0_ack", if4.irq_pend, 4'b1000);
        check("ch0_ack_irq_n", if4.irq_n, 0);
        wr(2, 3, K_ACKN, 8'h00);
        check("ch3_ack", if4.irq_pend, 4'b0000);
        check("ch3_ack_irq_n", if4.irq_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
